// File: rtl/mont_nprime_inv_if.sv
// Interface for mont_nprime_inv: start/operand from the requester, result back.
// Optional macro MODINV_ODD_CHECK_EN adds the err signal for even-modulus rejection.
interface mont_nprime_inv_if #(
  parameter int N_WIDTH = 4096,
  parameter int W       = 64
);
  logic               go;
  logic [N_WIDTH-1:0] n;
  logic [W-1:0]       modulo_inv;
  logic               valid;
`ifdef MODINV_ODD_CHECK_EN
  logic               err;
`endif

  modport master (
    output go,
    output n,
    input  modulo_inv,
    input  valid
`ifdef MODINV_ODD_CHECK_EN
    , input err
`endif
  );

  modport slave (
    input  go,
    input  n,
    output modulo_inv,
    output valid
`ifdef MODINV_ODD_CHECK_EN
    , output err
`endif
  );
endinterface

// File: rtl/mont_nprime_inv.sv
// mont_nprime_inv: computes nprime0 = -(n0^-1) mod 2^W from the low word of
// an odd modulus using bit-serial Hensel lifting, one bit per clock, no multiplier.
// Optional macro MODINV_ODD_CHECK_EN: even moduli are rejected in one cycle
// with err=1 and a zero result instead of running the iteration.
module mont_nprime_inv #(
  parameter int N_WIDTH = 4096,
  parameter int W       = 64
) (
  input logic               clk,
  input logic               reset,
  mont_nprime_inv_if.slave  bus
);

  localparam int IW = $clog2(W);
  localparam logic [IW-1:0] LAST_BIT = IW'(W - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  n0;
  logic [W-1:0]  x;
  logic [W-1:0]  p;
  logic [IW-1:0] i;
`ifdef MODINV_ODD_CHECK_EN
  logic          even_n;
`endif

  // Only the low word of the modulus matters; the rest is intentionally dropped.
  logic unused_n_hi;
  assign unused_n_hi = ^bus.n[N_WIDTH-1:W];

  // Control FSM and datapath: x accumulates the inverse bit by bit while p
  // tracks n0*x mod 2^W, so p[i] tells us whether bit i of x must be set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      n0             <= '0;
      x              <= '0;
      p              <= '0;
      i              <= '0;
      bus.modulo_inv <= '0;
      bus.valid      <= 1'b0;
`ifdef MODINV_ODD_CHECK_EN
      bus.err        <= 1'b0;
      even_n         <= 1'b0;
`endif
    end else begin
      bus.valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.go) begin
            n0 <= bus.n[W-1:0];
            x  <= W'(1);
            p  <= bus.n[W-1:0];
            i  <= IW'(1);
`ifdef MODINV_ODD_CHECK_EN
            if (!bus.n[0]) begin
              even_n <= 1'b1;
              state  <= DONE;
            end else begin
              even_n  <= 1'b0;
              bus.err <= 1'b0;
              state   <= ITER;
            end
`else
            state <= ITER;
`endif
          end
        end

        ITER: begin
          if (p[i]) begin
            x <= x | (W'(1) << i);
            p <= p + (n0 << i);
          end
          i <= i + IW'(1);
          if (i == LAST_BIT) begin
            state <= DONE;
          end
        end

        DONE: begin
`ifdef MODINV_ODD_CHECK_EN
          if (even_n) begin
            bus.modulo_inv <= '0;
            bus.err        <= 1'b1;
          end else begin
            bus.modulo_inv <= (~x) + W'(1);
          end
`else
          bus.modulo_inv <= (~x) + W'(1);
`endif
          bus.valid <= 1'b1;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_nprime_inv.sv
// Scoreboard testbench for mont_nprime_inv. Expected results come from a
// Newton-iteration inverse model and known constants; a monitor pops and
// compares on every valid pulse, including the cycle it arrived on.
// Optional macro MODINV_ODD_CHECK_EN enables the even-modulus err checks.
module tb_mont_nprime_inv;

  localparam int N_WIDTH = 4096;
  localparam int W       = 64;
  localparam int NUM_RANDOM = 200;

  typedef struct {
    logic [W-1:0] val;
    logic [W-1:0] n0;
    logic         err;
    int           cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   vectors;
  int   miscompares;
  exp_t sb[$];

  mont_nprime_inv_if #(.N_WIDTH(N_WIDTH), .W(W)) bus ();

  mont_nprime_inv #(.N_WIDTH(N_WIDTH), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Modular inverse by Newton iteration: n*n == 1 mod 8 seeds 3 good bits,
  // each step doubles them, so six steps cover 64 bits.
  function automatic logic [W-1:0] ref_nprime(input logic [W-1:0] n0);
    logic [W-1:0] xr;
    xr = n0;
    for (int k = 0; k < 6; k++) xr = xr * (W'(2) - n0 * xr);
    return -xr;
  endfunction

  function automatic logic [N_WIDTH-1:0] rand_wide();
    logic [N_WIDTH-1:0] v;
    for (int j = 0; j < N_WIDTH / 32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%016h required 0x%016h", name, act, req);
    end
  endtask

  // Issue one go pulse and queue the result expected lat edges later.
  task automatic apply_stimulus(input logic [N_WIDTH-1:0] nv, input logic [W-1:0] req,
                                input logic err, input int lat);
    exp_t e;
    @(negedge clk);
    bus.n  = nv;
    bus.go = 1'b1;
    e.val = req;
    e.n0  = nv[W-1:0];
    e.err = err;
    e.cyc = cyc + 1 + lat;
    sb.push_back(e);
    @(negedge clk);
    bus.go = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (sb.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain_timeout: %0d results still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every valid pulse must match the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.valid === 1'b1) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_valid at cycle %0d: valid=1 required 0", cyc);
        end else begin
          e = sb.pop_front();
          check_output("result", bus.modulo_inv, e.val);
          check_output("latency", W'(cyc), W'(e.cyc));
`ifdef MODINV_ODD_CHECK_EN
          check_output("err", W'(bus.err), W'(e.err));
          if (!e.err) check_output("product", e.n0 * bus.modulo_inv, {W{1'b1}});
`else
          check_output("product", e.n0 * bus.modulo_inv, {W{1'b1}});
`endif
        end
      end
    end
  end

  initial begin
    logic [N_WIDTH-1:0] nv;
    logic [W-1:0]       last;
    int                 k;

    cyc = 0;
    vectors = 0;
    miscompares = 0;
    reset  = 1'b1;
    bus.go = 1'b0;
    bus.n  = '0;
    repeat (3) @(negedge clk);
    check_output("reset_valid", W'(bus.valid), '0);
    check_output("reset_result", bus.modulo_inv, '0);
`ifdef MODINV_ODD_CHECK_EN
    check_output("reset_err", W'(bus.err), '0);
`endif
    reset = 1'b0;

    // Known constants with random upper garbage.
    nv = rand_wide(); nv[W-1:0] = 64'd3;
    apply_stimulus(nv, 64'h5555555555555555, 1'b0, W);
    wait_drain(100);
    nv = rand_wide(); nv[W-1:0] = 64'd5;
    apply_stimulus(nv, 64'h3333333333333333, 1'b0, W);
    wait_drain(100);
    nv = rand_wide(); nv[W-1:0] = 64'd1;
    apply_stimulus(nv, 64'hFFFFFFFFFFFFFFFF, 1'b0, W);
    wait_drain(100);
    nv = rand_wide(); nv[W-1:0] = 64'hFFFFFFFFFFFFFFFF;
    apply_stimulus(nv, 64'h0000000000000001, 1'b0, W);
    wait_drain(100);
    nv = rand_wide(); nv[W-1:0] = 64'd77;
    apply_stimulus(nv, ref_nprime(64'd77), 1'b0, W);
    wait_drain(100);

    // Busy handling: n change at +5 and a second go at +10 must both be ignored.
    nv = rand_wide(); nv[0] = 1'b1;
    last = ref_nprime(nv[W-1:0]);
    apply_stimulus(nv, last, 1'b0, W);
    repeat (4) @(negedge clk);
    bus.n = rand_wide();
    repeat (5) @(negedge clk);
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    wait_drain(100);
    repeat (80) @(negedge clk);
    check_output("hold_after_idle", bus.modulo_inv, last);

    // go held high: back-to-back runs, the second starting one edge after valid.
    nv = rand_wide(); nv[0] = 1'b1;
    last = ref_nprime(nv[W-1:0]);
    @(negedge clk);
    bus.n  = nv;
    bus.go = 1'b1;
    k = cyc + 1;
    sb.push_back('{val: last, n0: nv[W-1:0], err: 1'b0, cyc: k + W});
    sb.push_back('{val: last, n0: nv[W-1:0], err: 1'b0, cyc: k + 2 * W + 1});
    while (cyc < k + W + 1) @(negedge clk);
    bus.go = 1'b0;
    wait_drain(200);

    // Asynchronous reset mid-run aborts the result.
    nv = rand_wide(); nv[0] = 1'b1;
    apply_stimulus(nv, ref_nprime(nv[W-1:0]), 1'b0, W);
    repeat (29) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check_output("abort_valid", W'(bus.valid), '0);
    check_output("abort_result", bus.modulo_inv, '0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (80) @(negedge clk);
    nv = rand_wide(); nv[0] = 1'b1;
    apply_stimulus(nv, ref_nprime(nv[W-1:0]), 1'b0, W);
    wait_drain(100);

`ifdef MODINV_ODD_CHECK_EN
    // Even modulus rejected in one edge; the next odd run clears err.
    nv = rand_wide(); nv[W-1:0] = 64'd76;
    apply_stimulus(nv, '0, 1'b1, 1);
    wait_drain(20);
    nv = rand_wide(); nv[W-1:0] = 64'd3;
    apply_stimulus(nv, 64'h5555555555555555, 1'b0, W);
    wait_drain(100);
`endif

    // Random odd moduli against the reference model.
    for (int r = 0; r < NUM_RANDOM; r++) begin
      nv = rand_wide(); nv[0] = 1'b1;
      apply_stimulus(nv, ref_nprime(nv[W-1:0]), 1'b0, W);
      wait_drain(100);
    end

    repeat (80) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
